sorted_threshold_fire: RTL and testbench

SORTED_THRESHOLD_FIRE -- requirements
Module: sorted_threshold_fire

---
 rtl/sorted_threshold_fire.sv | 182 ++++++++++++++++++
 tb/tb_sorted_threshold_fire.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sorted_threshold_fire.sv
// -----------------------------------------------------------------------------
// sorted_threshold_fire
//
// Purpose:
//   Threshold "neuron" that sits behind a bitonic sorter. The sorter presents
//   its inputs as a thermometer code (bit 0 = maximum, ones at low indices).
//   The block watches one evaluation window of GAMMA ticks. On each tick it
//   looks at sorted_in[THRESH-1]: this bit is 1 exactly when at least THRESH
//   inputs are active. The first tick on which that happens produces a
//   one-cycle spike and is recorded as the fire time. At the end of the
//   window the result is held until the consumer accepts it.
//
// Optional feature (compile-time macro THERM_CHECK_EN):
//   When defined, every RUN tick checks sorted_in for an illegal thermometer
//   code (a 1 directly above a 0). Any violation sets the sticky therm_err
//   flag, which stays set until reset and never affects firing.
//   When undefined, therm_err is tied low and no check logic is built.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   start         in   1   open a new window (IDLE only)
//   tick          in   1   one-cycle strobe advancing window time
//   sorted_in     in   N   thermometer-coded sorter output
//   spike_out     out  1   one-cycle pulse on the first threshold crossing
//   fire_time     out  TW  tick index of the first fire, GAMMA = no fire
//   result_valid  out  1   window result available (HOLD)
//   result_ready  in   1   consumer accepts the result
//   busy          out  1   high in RUN and HOLD
//   therm_err     out  1   sticky illegal-code flag (THERM_CHECK_EN only)
// -----------------------------------------------------------------------------
module sorted_threshold_fire #(
  parameter int N      = 16,
  parameter int THRESH = 8,
  parameter int GAMMA  = 16,
  parameter int TW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          tick,
  input  logic [N-1:0]  sorted_in,
  output logic          spike_out,
  output logic [TW-1:0] fire_time,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          busy,
  output logic          therm_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Last tick index of a window and the "no fire" marker.
  localparam logic [TW-1:0] T_LAST  = TW'(GAMMA - 1);
  localparam logic [TW-1:0] FT_NONE = TW'(GAMMA);

  state_t        r_state;
  logic [TW-1:0] r_t;
  logic          r_fired;
  logic          r_spike;
  logic [TW-1:0] r_fire_time;

  state_t        w_state_next;
  logic [TW-1:0] w_t_next;
  logic          w_fired_next;
  logic          w_spike_next;
  logic [TW-1:0] w_fire_time_next;

  logic          w_run_tick;
  logic          w_sample;

  assign w_run_tick = (r_state == S_RUN) && tick;
  // For a legal code this bit is 1 iff at least THRESH inputs are active.
  assign w_sample   = sorted_in[THRESH-1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_fired     <= 1'b0;
      r_spike     <= 1'b0;
      r_fire_time <= FT_NONE;
    end else begin
      r_state     <= w_state_next;
      r_t         <= w_t_next;
      r_fired     <= w_fired_next;
      r_spike     <= w_spike_next;
      r_fire_time <= w_fire_time_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_t_next         = r_t;
    w_fired_next     = r_fired;
    w_spike_next     = 1'b0;          // spike is a single-cycle pulse
    w_fire_time_next = r_fire_time;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next     = S_RUN;
          w_t_next         = '0;
          w_fired_next     = 1'b0;
          w_fire_time_next = FT_NONE;
        end
      end

      S_RUN: begin
        if (tick) begin
          if (w_sample && !r_fired) begin
            w_spike_next     = 1'b1;
            w_fire_time_next = r_t;
            w_fired_next     = 1'b1;
          end
          // The final tick closes the window; t stays at GAMMA-1 so it
          // never runs past the last legal index.
          if (r_t == T_LAST) begin
            w_state_next = S_HOLD;
          end else begin
            w_t_next = r_t + 1'b1;
          end
        end
      end

      S_HOLD: begin
        // start is deliberately ignored here, even alongside result_ready.
        if (result_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign spike_out    = r_spike;
  assign fire_time    = r_fire_time;
  assign result_valid = (r_state == S_HOLD);
  assign busy         = (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Thermometer-code integrity check
  // ---------------------------------------------------------------------------
`ifdef THERM_CHECK_EN
  logic [N-2:0] w_inversion;
  logic         r_therm_err;

  // An inversion is a 1 sitting directly above a 0.
  for (genvar gi = 0; gi < N - 1; gi++) begin : g_inversion
    assign w_inversion[gi] = sorted_in[gi+1] & ~sorted_in[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_therm_err <= 1'b0;
    end else if (w_run_tick && (|w_inversion)) begin
      r_therm_err <= 1'b1;
    end
  end

  assign therm_err = r_therm_err;
`else
  // Only the threshold bit is used for firing; keep the rest visibly unused.
  logic w_unused_sorted;
  assign w_unused_sorted = ^sorted_in;
  assign therm_err       = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_threshold_fire.sv
module tb_sorted_threshold_fire;

  localparam int N      = 16;
  localparam int THRESH = 8;
  localparam int GAMMA  = 16;
  localparam int TW     = 8;

`ifdef THERM_CHECK_EN
  localparam bit THERM_ON = 1'b1;
`else
  localparam bit THERM_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          tick;
  logic [N-1:0]  sorted_in;
  logic          spike_out;
  logic [TW-1:0] fire_time;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          therm_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_therm = 1'b0;

  sorted_threshold_fire #(
    .N(N), .THRESH(THRESH), .GAMMA(GAMMA), .TW(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .tick(tick),
    .sorted_in(sorted_in),
    .spike_out(spike_out),
    .fire_time(fire_time),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy(busy),
    .therm_err(therm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Legal thermometer code with c active inputs.
  function automatic logic [N-1:0] therm(input int c);
    logic [N:0] v;
    v = ({{N{1'b0}}, 1'b1} << c) - 1'b1;
    return v[N-1:0];
  endfunction

  // One evaluation window. ft = tick index at which the count first
  // reaches THRESH (GAMMA or more = never). inject_bad puts an illegal code
  // on tick 0 (requires ft > 0). reset_at = tick index at which reset hits
  // (-1 = none).
  task automatic run_window(input int ft, input bit inject_bad, input int reset_at);
    int exp_ft;
    int cnt;
    int spikes;
    exp_ft = (ft >= GAMMA) ? GAMMA : ft;
    spikes = 0;

    repeat ($urandom_range(0, 2)) begin
      start = 1'b0; tick = $urandom_range(0, 1); sorted_in = N'($urandom);
      result_ready = $urandom_range(0, 1);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_valid", result_valid, 0);
      chk("idle_spike", spike_out, 0);
    end

    start = 1'b1; tick = 1'b0; result_ready = 1'b0;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", result_valid, 0);
    chk("start_fire_time", fire_time, GAMMA);
    chk("start_therm", therm_err, exp_therm);

    for (int j = 0; j < GAMMA; j++) begin
      repeat ($urandom_range(0, 2)) begin
        tick = 1'b0; sorted_in = N'($urandom); start = $urandom_range(0, 1);
        step();
        chk("gap_spike", spike_out, 0);
        chk("gap_valid", result_valid, 0);
        chk("gap_busy", busy, 1);
      end

      if (j == reset_at) begin
        tick = 1'b1; sorted_in = '1; start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_therm = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_spike", spike_out, 0);
        chk("rst_fire_time", fire_time, GAMMA);
        chk("rst_therm", therm_err, 0);
        tick = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) begin
          step();
          chk("post_rst_valid", result_valid, 0);
          chk("post_rst_busy", busy, 0);
        end
        $display("window ft=%0d aborted by reset at tick %0d", ft, j);
        return;
      end

      if (j < exp_ft)       cnt = $urandom_range(0, THRESH - 1);
      else if (j == exp_ft) cnt = $urandom_range(THRESH, N);
      else                  cnt = $urandom_range(0, N);
      sorted_in = therm(cnt);
      if (inject_bad && j == 0) begin
        sorted_in = 16'h0005;
        if (THERM_ON) exp_therm = 1'b1;
      end
      tick = 1'b1; start = $urandom_range(0, 1);
      step();
      tick = 1'b0; start = 1'b0;
      if (spike_out) spikes++;
      chk("tick_spike", spike_out, (j == exp_ft) ? 1 : 0);
      chk("tick_valid", result_valid, (j == GAMMA - 1) ? 1 : 0);
      chk("tick_busy", busy, 1);
      chk("tick_therm", therm_err, exp_therm);
      if (j == exp_ft) chk("tick_fire_time", fire_time, j);
    end

    repeat ($urandom_range(0, 3)) begin
      result_ready = 1'b0; start = $urandom_range(0, 1); sorted_in = N'($urandom);
      tick = $urandom_range(0, 1);
      step();
      chk("hold_valid", result_valid, 1);
      chk("hold_fire_time", fire_time, exp_ft);
      chk("hold_spike", spike_out, 0);
      chk("hold_busy", busy, 1);
    end

    // Release with start also high: must return to IDLE only.
    result_ready = 1'b1; start = $urandom_range(0, 1); tick = 1'b0;
    step();
    result_ready = 1'b0; start = 1'b0;
    chk("release_valid", result_valid, 0);
    chk("release_busy", busy, 0);
    step();
    chk("idle_after_busy", busy, 0);
    chk("spike_count", spikes, (exp_ft < GAMMA) ? 1 : 0);
    chk("idle_therm", therm_err, exp_therm);
    $display("window ft=%0d fire_time=%0d spikes=%0d therm_err=%0d", ft, exp_ft, spikes, therm_err);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; sorted_in = '0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_spike", spike_out, 0);
    chk("reset_fire_time", fire_time, GAMMA);
    chk("reset_therm", therm_err, 0);
    rst_n = 1'b1;
    step();

    run_window(4, 1'b0, -1);
    run_window(GAMMA, 1'b0, -1);
    run_window(GAMMA - 1, 1'b0, -1);
    run_window(6, 1'b0, 7);
    run_window(0, 1'b0, -1);
    for (int w = 0; w < 8; w++) run_window($urandom_range(0, GAMMA), 1'b0, -1);
    run_window(9, 1'b1, -1);
    run_window($urandom_range(0, GAMMA), 1'b0, -1);
    run_window(GAMMA, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
